// File: rtl/cv32e40p_aligner_tmr.sv
// Instruction aligner feeding the triplicated compressed decoder; realigns fetch words
// into instruction-aligned words, with optionally triplicated and scrubbed state.
module cv32e40p_aligner_tmr #(
  parameter int unsigned TMR_STATE = 1,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid_i,
  output logic             fetch_ready_o,
  input  logic [31:0]      fetch_rdata_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_addr_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [2:0][31:0] instr_aligned_o,
  output logic [31:0]      pc_o,
  output logic             state_err_o
);

  localparam logic [2:0] ALIGNED32         = 3'b000;
  localparam logic [2:0] MISALIGNED32      = 3'b001;
  localparam logic [2:0] MISALIGNED16      = 3'b010;
  localparam logic [2:0] BRANCH_MISALIGNED = 3'b100;

  logic [2:0]  st_v, st_n;
  logic [15:0] h_v, h_n;
  logic [31:0] pc_v, pc_n;
  logic [31:0] instr;
  logic        iv, fr, err;
  logic        fire;

  function automatic logic legal(input logic [2:0] s);
    return (s == ALIGNED32) || (s == MISALIGNED32) ||
           (s == MISALIGNED16) || (s == BRANCH_MISALIGNED);
  endfunction

  assign fire = fetch_valid_i && instr_ready_i;

  always_comb begin
    st_n  = st_v;
    h_n   = h_v;
    pc_n  = pc_v;
    iv    = 1'b0;
    fr    = 1'b0;
    instr = fetch_rdata_i;
    if (branch_i) begin
      pc_n = {branch_addr_i[31:1], 1'b0};
      h_n  = '0;
      st_n = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED32;
    end else begin
      case (st_v)
        MISALIGNED32: begin
          iv    = fetch_valid_i;
          instr = {fetch_rdata_i[15:0], h_v};
          if (fire) begin
            fr   = 1'b1;
            h_n  = fetch_rdata_i[31:16];
            pc_n = pc_v + 32'd4;
            st_n = (fetch_rdata_i[17:16] != 2'b11) ? MISALIGNED16 : MISALIGNED32;
          end
        end
        MISALIGNED16: begin
          iv    = 1'b1;
          instr = {16'h0, h_v};
          if (instr_ready_i) begin
            pc_n = pc_v + 32'd2;
            st_n = ALIGNED32;
          end
        end
        BRANCH_MISALIGNED: begin
          if (fetch_rdata_i[17:16] != 2'b11) begin
            iv    = fetch_valid_i;
            instr = {16'h0, fetch_rdata_i[31:16]};
            if (fire) begin
              fr   = 1'b1;
              pc_n = pc_v + 32'd2;
              st_n = ALIGNED32;
            end
          end else if (fire) begin
            // upper half starts a 32-bit instruction: swallow the word, emit nothing yet
            fr   = 1'b1;
            h_n  = fetch_rdata_i[31:16];
            st_n = MISALIGNED32;
          end
        end
        default: begin
          // ALIGNED32; an illegal voted encoding also lands here
          iv    = fetch_valid_i;
          instr = fetch_rdata_i;
          if (fire) begin
            fr  = 1'b1;
            h_n = fetch_rdata_i[31:16];
            if (fetch_rdata_i[1:0] == 2'b11) begin
              pc_n = pc_v + 32'd4;
              st_n = ALIGNED32;
            end else begin
              pc_n = pc_v + 32'd2;
              st_n = (fetch_rdata_i[17:16] != 2'b11) ? MISALIGNED16 : MISALIGNED32;
            end
          end
        end
      endcase
    end
  end

  if (TMR_STATE != 0) begin : g_tmr
    logic [2:0]  st_r0, st_r1, st_r2;
    logic [15:0] h_r0, h_r1, h_r2;
    logic [31:0] pc_r0, pc_r1, pc_r2;

    // every copy gets the same next value each cycle, which also scrubs upsets
    always_ff @(posedge clk) begin
      if (rst) begin
        st_r0 <= ALIGNED32; st_r1 <= ALIGNED32; st_r2 <= ALIGNED32;
        h_r0  <= '0;        h_r1  <= '0;        h_r2  <= '0;
        pc_r0 <= RESET_PC;  pc_r1 <= RESET_PC;  pc_r2 <= RESET_PC;
      end else begin
        st_r0 <= st_n; st_r1 <= st_n; st_r2 <= st_n;
        h_r0  <= h_n;  h_r1  <= h_n;  h_r2  <= h_n;
        pc_r0 <= pc_n; pc_r1 <= pc_n; pc_r2 <= pc_n;
      end
    end

    assign st_v = (st_r0 & st_r1) | (st_r0 & st_r2) | (st_r1 & st_r2);
    assign h_v  = (h_r0 & h_r1) | (h_r0 & h_r2) | (h_r1 & h_r2);
    assign pc_v = (pc_r0 & pc_r1) | (pc_r0 & pc_r2) | (pc_r1 & pc_r2);
    assign err  = (st_r0 != st_r1) || (st_r0 != st_r2) ||
                  (h_r0 != h_r1) || (h_r0 != h_r2) ||
                  (pc_r0 != pc_r1) || (pc_r0 != pc_r2) ||
                  !legal(st_r0) || !legal(st_r1) || !legal(st_r2);
  end else begin : g_single
    logic [2:0]  st_r;
    logic [15:0] h_r;
    logic [31:0] pc_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_r <= ALIGNED32;
        h_r  <= '0;
        pc_r <= RESET_PC;
      end else begin
        st_r <= st_n;
        h_r  <= h_n;
        pc_r <= pc_n;
      end
    end

    assign st_v = st_r;
    assign h_v  = h_r;
    assign pc_v = pc_r;
    assign err  = 1'b0;
  end

  assign instr_valid_o   = iv && !rst;
  assign fetch_ready_o   = fr && !rst;
  assign state_err_o     = err && !rst;
  assign pc_o            = pc_v;
  assign instr_aligned_o = {3{instr}};

endmodule

// File: doc/cv32e40p_aligner_tmr.md
Name: cv32e40p_aligner_tmr

Overview:
- Instruction aligner directly upstream of the fault-tolerant compressed decoder.
- Takes 32-bit fetch words from the prefetch buffer and realigns them into instruction-aligned 32-bit words:
  - a compressed instruction always sits in bits [15:0];
  - a 32-bit instruction may straddle two fetch words.
- Drives three identical output copies for the decoder's triplicated input.
- Optionally triplicates its own state (FSM, held halfword, PC) with majority voting and scrubbing.

Parameters:
TMR_STATE, 1, 1 = state/halfword/PC registers triplicated and majority-voted; 0 = single copy, state_err_o tied 0
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
fetch_valid_i  input  1  fetch_rdata_i valid
fetch_ready_o  output  1  fetch word consumed this cycle (transfer = fetch_valid_i & fetch_ready_o)
fetch_rdata_i  input  32  word-aligned fetch data
branch_i  input  1  redirect; current fetch data is stale
branch_addr_i  input  32  redirect target; bit 0 ignored
instr_valid_o  output  1  aligned instruction valid
instr_ready_i  input  1  downstream accepts (transfer = instr_valid_o & instr_ready_i)
instr_aligned_o  output  3x32  three identical copies of the aligned instruction
pc_o  output  32  address of instr_aligned_o
state_err_o  output  1  replica disagreement in any triplicated register (current cycle)

Behaviour:
- Reset (rst=1 at posedge):
  - state=ALIGNED32, held halfword H=16'h0, pc=RESET_PC, in all copies.
  - During and after reset: instr_valid_o=0, fetch_ready_o=0, state_err_o=0 until fetch_valid_i is seen.
  - Reset mid-operation discards H and any pending instruction.
- States:
  - ALIGNED32: pc word-aligned.
  - MISALIGNED32: H holds the low half of a 32-bit instruction.
  - MISALIGNED16: H holds a complete compressed instruction.
  - BRANCH_MISALIGNED: target has pc[1]=1 and the first word is pending.
- ALIGNED32:
  - instr_valid_o=fetch_valid_i; out=fetch_rdata_i.
  - On transfer: fetch_ready_o=1, H<=rdata[31:16].
  - If rdata[1:0]==2'b11: pc+=4, stay in ALIGNED32.
  - Else pc+=2; next state is MISALIGNED16 if rdata[17:16]!=2'b11, otherwise MISALIGNED32.
- MISALIGNED32:
  - instr_valid_o=fetch_valid_i; out={rdata[15:0],H}.
  - On transfer: consume word, H<=rdata[31:16], pc+=4.
  - Next state is MISALIGNED16 if rdata[17:16]!=2'b11, otherwise MISALIGNED32.
- MISALIGNED16:
  - instr_valid_o=1 regardless of fetch_valid_i; out={16'h0,H}; fetch_ready_o=0.
  - On transfer: pc+=2, go to ALIGNED32.
- BRANCH_MISALIGNED:
  - If rdata[17:16]!=2'b11: instr_valid_o=fetch_valid_i, out={16'h0,rdata[31:16]}; on transfer consume word, pc+=2, go to ALIGNED32.
  - Else: instr_valid_o=0, fetch_ready_o=fetch_valid_i, H<=rdata[31:16], go to MISALIGNED32 (pc unchanged).
- Downstream stall: no transfer while instr_ready_i=0. No register changes; fetch_ready_o=0. Outputs stay stable while fetch_valid_i stays high.
- branch_i:
  - Highest priority, below rst only.
  - That cycle: instr_valid_o=0, fetch_ready_o=0.
  - pc<={branch_addr_i[31:1],1'b0}; H<=0; state<=BRANCH_MISALIGNED if branch_addr_i[1], else ALIGNED32.
  - A simultaneous handshake is ignored.
- Arithmetic: pc increments are modulo 2^32; wrap from 32'hFFFF_FFFE by +2 gives 0.
- Latency: combinational from fetch input to instr output (0 cycles). State updates at the posedge after a transfer.
- TMR (TMR_STATE=1):
  - Each of state, H and pc is held in 3 copies; every use reads the bitwise 2-of-3 majority.
  - All copies are written with the same next value every cycle (scrubbing). A copy corrupted while idle is repaired at the next edge, even with no transfer.
  - state_err_o=1 combinationally while any bit differs across copies, or while any copy holds an illegal state encoding.
  - An illegal voted state is treated as ALIGNED32.
- instr_aligned_o[0..2] are always equal; no replication of the combinational path.

Test Plan:
1. Reset, then a stream of 32-bit words 32'h0000_0013 at addr 0, instr_ready_i=1 → one instruction per cycle; pc_o 0,4,8; fetch_ready_o=1 each cycle.
2. Word 32'h4501_4581 (two compressed) → cycle 1: out=32'h4501_4581, pc=0, fetch_ready_o=1. Cycle 2 (fetch_valid_i=0): out=32'h0000_4501, pc=2, valid=1. Cycle 3: ALIGNED32, pc=4.
3. Word 32'h0513_4581 then 32'h1234_0000 → cycle 1: out low=4581, pc=0. Cycle 2: out=32'h0000_0513, pc=2; 32-bit straddle assembled from H=16'h0513 + next low half 16'h0000. pc then 6, state MISALIGNED16 or MISALIGNED32 per bits [17:16] of the second word.
4. branch_i with branch_addr_i=32'h0000_0102 alongside a valid fetch → no valid, no consume that cycle. Next word 32'h4581_xxxx → out=32'h0000_4581, pc=0x102, then ALIGNED32 at 0x104.
5. instr_ready_i=0 for 3 cycles with fetch_valid_i=1 → fetch_ready_o=0, pc_o and out stable. Deassert → single transfer.
6. TMR_STATE=1: force one pc copy to 32'hDEAD_BEEF mid-stream → state_err_o=1 that cycle, pc_o unaffected, state_err_o=0 the next cycle. Force an illegal state in one copy → same behaviour.
